// File: rtl/mc_riscv_core.sv
// ---------------------------------------------------------------------------
// mc_riscv_core
// Multi-cycle RV32 core (lw, sw, add/sub/and/or/slt, addi/andi/ori/slti,
// beq/bne, jal, lui) with one unified memory port. The port uses a req/ready
// handshake, so the memory may add any number of wait states.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   NREGS     32 (RV32I) or 16 (RV32E) architectural registers
//   TRAP_VEC  trap handler address, used only when MC_CORE_TRAP_EN is defined
//
// Configuration macro
//   MC_CORE_TRAP_EN  undefined: an illegal instruction stops the core in HALT.
//                    defined:   an illegal instruction records trap_epc and
//                               jumps to TRAP_VEC; HALT is never entered.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   mem_req/mem_we    request and direction, held stable until mem_ready
//   mem_addr          word-aligned access address
//   mem_wdata         store data
//   mem_rdata         read data, taken in the mem_req & mem_ready cycle
//   mem_ready         completes the current access
//   pc, instr         debug view of PC and instruction register
//   halted            core is stopped in HALT
//   trap_epc          PC of the last faulting instruction
// ---------------------------------------------------------------------------
module mc_riscv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        halted,
  output logic [31:0] trap_epc
);

  localparam int RW = $clog2(NREGS);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, old_pc_q, old_pc_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, data_q, data_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] trap_epc_q, trap_epc_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, halted_q, halted_d;

  logic [31:0] rf_q [NREGS];
  logic        rf_we;
  logic [31:0] rf_wdata;

  // Instruction fields and immediates
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, rs1_val, rs2_val;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                   instr_q[11:8], 1'b0};
  assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                   instr_q[30:21], 1'b0};
  assign imm_u  = {instr_q[31:12], 12'b0};

  // x0 is hard-wired to zero on the read side; writes to it are dropped below.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1[RW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2[RW-1:0]];

  // Decode
  logic alu_f3_ok, is_lw, is_sw, is_r, is_i, is_br, is_jal, is_lui;
  logic uses_rs1, uses_rs2, uses_rd, bad_reg, legal;

  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                     (funct3 == 3'b110) || (funct3 == 3'b010);
  assign is_lw  = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw  = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_r   = (opcode == 7'b0110011) &&
                  (((funct7 == 7'b0000000) && alu_f3_ok) ||
                   ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
  assign is_i   = (opcode == 7'b0010011) && alu_f3_ok;
  assign is_br  = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
  assign is_jal = (opcode == 7'b1101111);
  assign is_lui = (opcode == 7'b0110111);

  // RV32E: only the register fields an encoding actually uses are checked.
  assign uses_rs1 = is_lw | is_sw | is_r | is_i | is_br;
  assign uses_rs2 = is_sw | is_r | is_br;
  assign uses_rd  = is_lw | is_r | is_i | is_jal | is_lui;
  assign bad_reg  = (NREGS < 32) &&
                    ((uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) || (uses_rd && rd[4]));
  assign legal    = (uses_rs1 | uses_rd) && !bad_reg;

  function automatic logic [31:0] alu(input logic [31:0] x, input logic [31:0] y,
                                      input logic [2:0] f3, input logic sub);
    case (f3)
      3'b111:  return x & y;
      3'b110:  return x | y;
      3'b010:  return {31'b0, $signed(x) < $signed(y)};
      default: return sub ? x - y : x + y;
    endcase
  endfunction

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statements can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    old_pc_d    = old_pc_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_out_d   = alu_out_q;
    data_d      = data_q;
    halted_d    = halted_q;
    trap_epc_d  = trap_epc_q;
    rf_we       = 1'b0;
    rf_wdata    = 32'd0;

    case (state_q)
      S_FETCH: if (mem_req_q && mem_ready) begin
        instr_d  = mem_rdata;
        old_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        a_d       = rs1_val;
        b_d       = rs2_val;
        alu_out_d = old_pc_q + imm_b;
        if (!legal) begin
`ifdef MC_CORE_TRAP_EN
          trap_epc_d = old_pc_q;
          pc_d       = TRAP_VEC;
          state_d    = S_FETCH;
`else
          halted_d   = 1'b1;
          state_d    = S_HALT;
`endif
        end
        else if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_r)           state_d = S_EXECR;
        else if (is_i)           state_d = S_EXECI;
        else if (is_br)          state_d = S_BRANCH;
        else if (is_jal)         state_d = S_JAL;
        else                     state_d = S_LUI;
      end
      S_MEMADR: begin
        alu_out_d = a_q + (is_sw ? imm_s : imm_i);
        state_d   = is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: if (mem_req_q && mem_ready) begin
        data_d  = mem_rdata;
        state_d = S_MEMWB;
      end
      S_MEMWR: if (mem_req_q && mem_ready) state_d = S_FETCH;
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = data_q;
        state_d  = S_FETCH;
      end
      S_EXECR: begin
        alu_out_d = alu(a_q, b_q, funct3, funct7[5]);
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_out_d = alu(a_q, imm_i, funct3, 1'b0);
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_wdata = alu_out_q;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        // funct3[0] selects bne, which inverts the equality test.
        if ((a_q == b_q) != funct3[0]) pc_d = alu_out_q;
        state_d = S_FETCH;
      end
      S_JAL: begin
        rf_we    = 1'b1;
        rf_wdata = pc_q;
        pc_d     = old_pc_q + imm_j;
        state_d  = S_FETCH;
      end
      S_LUI: begin
        rf_we    = 1'b1;
        rf_wdata = imm_u;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Memory outputs are registered: they are set up from the state being
    // entered, so they are valid the first cycle of FETCH/MEMRD/MEMWR and,
    // because pc/alu_out/b do not move while waiting, stay stable until ready.
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_d)
      S_FETCH: begin
        mem_req_d  = 1'b1;
        mem_addr_d = {pc_d[31:2], 2'b00};
      end
      S_MEMRD: begin
        mem_req_d  = 1'b1;
        mem_addr_d = {alu_out_d[31:2], 2'b00};
      end
      S_MEMWR: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = {alu_out_d[31:2], 2'b00};
        mem_wdata_d = b_q;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      old_pc_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_out_q   <= '0;
      data_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      trap_epc_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      old_pc_q    <= old_pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_out_q   <= alu_out_d;
      data_q      <= data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
      trap_epc_q  <= trap_epc_d;
    end
  end

  // NOTE: the register file has no reset, so it maps onto plain RAM/flops
  // without a reset network; software must write a register before reading it.
  always_ff @(posedge clk) begin
    if (rf_we && !reset && (rd != 5'd0)) rf_q[rd[RW-1:0]] <= rf_wdata;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign halted    = halted_q;
  assign trap_epc  = trap_epc_q;

endmodule

// File: tb/tb_mc_riscv_core.sv
module tb_mc_riscv_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instr, trap_epc;

  logic        mem_req16, mem_we16, mem_ready16, halted16;
  logic [31:0] mem_addr16, mem_wdata16, mem_rdata16, pc16, instr16, trap_epc16;

  mc_riscv_core u_dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .instr(instr), .halted(halted),
    .trap_epc(trap_epc)
  );

  mc_riscv_core #(.NREGS(16)) u_dut16 (
    .clk(clk), .reset(reset), .mem_req(mem_req16), .mem_we(mem_we16),
    .mem_addr(mem_addr16), .mem_wdata(mem_wdata16), .mem_rdata(mem_rdata16),
    .mem_ready(mem_ready16), .pc(pc16), .instr(instr16), .halted(halted16),
    .trap_epc(trap_epc16)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] i_slti(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b010, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] i_andi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b111, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] i_ori(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b110, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] i_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] i_jal(input logic [4:0] rd, input logic [31:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] i_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  // ---------------- memory model and scoreboard ----------------
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         sb_q[$];
  logic [31:0] mem [256];
  int          wait_cycles = 0;
  int          wcnt = 0;
  int          cyc = 0;
  int          t0 = -1, tc = -1;
  int          rd_hs_count = 0;
  logic [31:0] last_rd_addr = '0;
  logic        rd200_wait = 1'b0;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_we;
  localparam logic [31:0] ILLEGAL = 32'hFFFF_FFFF;

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[9:2]] = word;
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    put(32'h00, i_addi(1, 0, 5));
    put(32'h04, i_addi(2, 0, 7));
    put(32'h08, i_r(7'h00, 3'b000, 3, 1, 2));      // add x3,x1,x2
    put(32'h0C, i_sw(3, 0, 32'h200));
    put(32'h10, i_lw(4, 0, 32'h200));
    put(32'h14, i_addi(0, 0, 9));
    put(32'h18, i_sw(4, 0, 32'h204));
    put(32'h1C, i_sw(0, 0, 32'h208));
    put(32'h20, i_lui(6, 20'hABCDE));
    put(32'h24, i_slti(7, 6, 0));
    put(32'h28, i_sw(6, 0, 32'h20C));
    put(32'h2C, i_sw(7, 0, 32'h210));
    put(32'h30, i_r(7'h20, 3'b000, 8, 1, 2));      // sub
    put(32'h34, i_r(7'h00, 3'b010, 9, 8, 1));      // slt x9,x8,x1
    put(32'h38, i_r(7'h00, 3'b111, 10, 1, 2));     // and
    put(32'h3C, i_r(7'h00, 3'b110, 11, 1, 2));     // or
    put(32'h40, i_andi(12, 8, 32'h0F0));
    put(32'h44, i_ori(13, 1, -16));
    put(32'h48, i_sw(8, 0, 32'h214));
    put(32'h4C, i_sw(9, 0, 32'h218));
    put(32'h50, i_sw(10, 0, 32'h21C));
    put(32'h54, i_sw(11, 0, 32'h220));
    put(32'h58, i_sw(12, 0, 32'h224));
    put(32'h5C, i_sw(13, 0, 32'h228));
    put(32'h60, i_r(7'h00, 3'b010, 14, 1, 8));     // slt x14,x1,x8
    put(32'h64, i_slti(15, 8, -1));
    put(32'h68, i_sw(14, 0, 32'h22C));
    put(32'h6C, i_sw(15, 0, 32'h230));
    put(32'h70, i_br(3'b000, 1, 1, 8));            // beq taken
    put(32'h74, i_sw(1, 0, 32'h2F0));
    put(32'h78, i_br(3'b001, 1, 1, 8));            // bne not taken
    put(32'h7C, i_sw(2, 0, 32'h234));
    put(32'h80, i_br(3'b001, 1, 2, 12));           // bne taken
    put(32'h84, i_sw(1, 0, 32'h2F4));
    put(32'h88, i_sw(1, 0, 32'h2F8));
    put(32'h8C, i_jal(5, 16));
    put(32'h90, i_sw(1, 0, 32'h2FC));
    put(32'h94, i_sw(1, 0, 32'h2FC));
    put(32'h98, i_sw(1, 0, 32'h2FC));
    put(32'h9C, i_sw(5, 0, 32'h238));
    put(32'hA0, i_br(3'b000, 0, 1, 8));            // beq not taken
    put(32'hA4, i_jal(0, 8));
    put(32'hA8, i_sw(1, 0, 32'h2FC));
    put(32'hAC, i_jal(0, 12));
    put(32'hB0, i_sw(16, 0, 32'h23C));
    put(32'hB4, i_jal(0, 12));
    put(32'hB8, i_addi(16, 0, 3));
    put(32'hBC, i_br(3'b000, 16, 16, -12));        // backward beq to 0xB0
    put(32'hC0, i_sw(0, 0, 32'h240));
    put(32'hC4, ILLEGAL);
    put(32'h100, i_sw(1, 0, 32'h300));
    put(32'h104, i_jal(0, 0));
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic push_program_expect();
    push_exp(32'h200, 32'd12);        push_exp(32'h204, 32'd12);
    push_exp(32'h208, 32'd0);         push_exp(32'h20C, 32'hABCDE000);
    push_exp(32'h210, 32'd1);         push_exp(32'h214, 32'hFFFFFFFE);
    push_exp(32'h218, 32'd1);         push_exp(32'h21C, 32'd5);
    push_exp(32'h220, 32'd7);         push_exp(32'h224, 32'h000000F0);
    push_exp(32'h228, 32'hFFFFFFF5);  push_exp(32'h22C, 32'd0);
    push_exp(32'h230, 32'd1);         push_exp(32'h234, 32'd7);
    push_exp(32'h238, 32'h90);        push_exp(32'h23C, 32'd3);
    push_exp(32'h240, 32'd0);
`ifdef MC_CORE_TRAP_EN
    push_exp(32'h300, 32'd5);
`endif
  endtask

  // Memory responder: decides mem_ready for the coming edge, and treats a
  // ready-with-request as the completed access.
  always @(negedge clk) begin
    wr_t e;
    cyc = cyc + 1;
    if (reset || !mem_req) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        lat_addr  = mem_addr;
        lat_we    = mem_we;
        lat_wdata = mem_wdata;
      end
      if (wcnt == wait_cycles) begin
        mem_ready = 1'b1;
        wcnt = 0;
        if (wait_cycles != 0) begin
          check("addr_stable", mem_addr, lat_addr);
          check("we_stable", {31'b0, mem_we}, {31'b0, lat_we});
          if (mem_we) check("wdata_stable", mem_wdata, lat_wdata);
        end
        if (mem_we) begin
          mem[mem_addr[9:2]] = mem_wdata;
          if (sb_q.size() == 0) check("sb_occupancy", 32'(sb_q.size()), 32'd1);
          else begin
            e = sb_q.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_data", mem_wdata, e.data);
          end
        end else begin
          mem_rdata    = mem[mem_addr[9:2]];
          rd_hs_count  = rd_hs_count + 1;
          last_rd_addr = mem_addr;
          if (mem_addr == 32'h0 && t0 < 0) t0 = cyc;
          if (mem_addr == 32'hC && tc < 0) tc = cyc;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = wcnt + 1;
        if (!mem_we && mem_addr == 32'h200) rd200_wait = 1'b1;
      end
    end
  end

  // RV32E instance: a legal lui followed by add x17,x1,x2 (illegal there).
  always @* begin
    case (mem_addr16)
      32'h0:   mem_rdata16 = i_lui(6, 20'hABCDE);
      32'h4:   mem_rdata16 = i_r(7'h00, 3'b000, 17, 1, 2);
      default: mem_rdata16 = i_jal(0, 0);
    endcase
  end

  task automatic start_phase(input int waits);
    reset = 1'b1;
    wait_cycles = waits;
    load_program();
    sb_q.delete();
    t0 = -1;
    tc = -1;
    rd200_wait = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic finish_phase();
`ifdef MC_CORE_TRAP_EN
    for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge clk);
    check("trap_sb_drained", 32'(sb_q.size()), 32'd0);
    check("trap_epc", trap_epc, 32'hC4);
    check("trap_not_halted", {31'b0, halted}, 32'd0);
`else
    for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
    check("halted", {31'b0, halted}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("halt_no_req", {31'b0, mem_req}, 32'd0);
    end
    check("halt_pc", pc, 32'hC8);
    check("halt_ir", instr, ILLEGAL);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("trap_epc_zero", trap_epc, 32'd0);
`endif
  endtask

  initial begin
    int n0;
    reset       = 1'b1;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    mem_ready16 = 1'b1;

    // Phase 1: zero-wait memory
    start_phase(0);
    check("rst_pc", pc, 32'h0);
    check("rst_ir", instr, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_trap_epc", trap_epc, 32'd0);
    push_program_expect();
    reset = 1'b0;
    finish_phase();
    check("lat_3alu_0wait", 32'(tc - t0), 32'd12);

`ifdef MC_CORE_TRAP_EN
    check("rv32e_trap_epc", trap_epc16, 32'h4);
    check("rv32e_not_halted", {31'b0, halted16}, 32'd0);
`else
    check("rv32e_halted", {31'b0, halted16}, 32'd1);
    check("rv32e_pc", pc16, 32'h8);
`endif

    // Phase 2: three wait states on every access
    start_phase(3);
    push_program_expect();
    reset = 1'b0;
    finish_phase();
    check("lat_3alu_3wait", 32'(tc - t0), 32'd21);

    // Phase 3: reset while lw waits on its data read
    start_phase(3);
    push_exp(32'h200, 32'd12);
    reset = 1'b0;
    for (int i = 0; i < 500 && !rd200_wait; i++) @(negedge clk);
    check("memrd_wait_seen", {31'b0, rd200_wait}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_req", {31'b0, mem_req}, 32'd0);
    check("rst_mid_pc", pc, 32'h0);
    reset = 1'b0;
    n0 = rd_hs_count;
    for (int i = 0; i < 50 && rd_hs_count == n0; i++) @(negedge clk);
    check("post_rst_fetch", last_rd_addr, 32'h0);
    check("post_rst_sb", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
